// File: rtl/instr_prefetch_buf_pkg.sv
// Shared widths, word size and FSM encoding for the instruction prefetch buffer.
package instr_prefetch_buf_pkg;

    localparam int IPF_ADDR_WIDTH  = 32;
    localparam int IPF_INSTR_WIDTH = 32;
    localparam int IPF_WORD_BYTES  = 4;

    typedef enum logic {
        IPF_IDLE   = 1'b0,
        IPF_STREAM = 1'b1
    } ipf_state_t;

endpackage

// File: rtl/ipf_fifo.sv
// Synchronous DEPTH-entry FIFO with push/pop/clear; clear wins over push and pop.
// Latency: a pushed entry is visible at the head on the following cycle.
// Backpressure: none inside; the owner must never push when full or pop when empty.
module ipf_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                         cpu_clk,
    input  logic                         cpu_rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_dat,
    input  logic                         pop,
    input  logic                         clear,
    output logic [WIDTH-1:0]             head_dat,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] count_q;

    always_ff @(posedge cpu_clk) begin
        if (push && !clear) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst || clear) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign head_dat = mem_q[rd_ptr_q];
    assign count    = count_q;
    assign empty    = (count_q == '0);

endmodule

// File: rtl/instr_prefetch_buf.sv
// Instruction prefetch buffer and bus master feeding IF; KRV_IPF_PERF_CNT_EN adds hit/redirect counters.
// Latency: FIFO hit or bus bypass returns the instruction one cycle after next_pc.
// Backpressure: bus requests stall once buffered plus live in-flight words reach DEPTH.
module instr_prefetch_buf
    import instr_prefetch_buf_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int ADDR_WIDTH  = IPF_ADDR_WIDTH,
    parameter int INSTR_WIDTH = IPF_INSTR_WIDTH
) (
    input  logic                   cpu_clk,
    input  logic                   cpu_rst,
    input  logic [ADDR_WIDTH-1:0]  next_pc,
    output logic                   instr_read_data_valid,
    output logic [INSTR_WIDTH-1:0] instr_read_data,
    output logic                   ibus_req,
    output logic [ADDR_WIDTH-1:0]  ibus_addr,
    input  logic                   ibus_gnt,
    input  logic                   ibus_rvalid,
    input  logic [INSTR_WIDTH-1:0] ibus_rdata
`ifdef KRV_IPF_PERF_CNT_EN
    ,
    output logic [31:0]            ipf_hit_cnt,
    output logic [31:0]            ipf_redirect_cnt
`endif
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int ENT_W = ADDR_WIDTH + INSTR_WIDTH;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0]  addr;
        logic [INSTR_WIDTH-1:0] instr;
    } ipf_entry_t;

    ipf_state_t             state_q, state_d;
    logic [ADDR_WIDTH-1:0]  cur_addr_q, stream_addr_q, stream_base, oldest_addr, pc_aligned;
    logic [CNT_W-1:0]       outstanding_q, discard_q, live, fifo_count;
    logic                   valid_q;
    logic [INSTR_WIDTH-1:0] data_q;
    ipf_entry_t             head, push_entry;
    logic [ENT_W-1:0]       head_dat;
    logic                   fifo_empty, misaligned, hold, hit, match_oldest;
    logic                   bypass, waiting, redirect, push, xfer;

    assign misaligned  = |next_pc[1:0];
    assign pc_aligned  = {next_pc[ADDR_WIDTH-1:2], 2'b00};
    // Non-discarded requests are the most recent ones, so the oldest sits live words behind stream_addr.
    assign live        = outstanding_q - discard_q;
    assign oldest_addr = stream_addr_q - (ADDR_WIDTH'(live) << 2);
    assign head        = head_dat;
    assign push_entry  = '{addr: oldest_addr, instr: ibus_rdata};

    assign hold         = !misaligned && valid_q && (next_pc == cur_addr_q);
    assign hit          = !misaligned && !hold && !fifo_empty && (head.addr == next_pc);
    assign match_oldest = !misaligned && !hold && fifo_empty && (live != '0) && (oldest_addr == next_pc);
    assign bypass       = match_oldest && ibus_rvalid && (discard_q == '0);
    assign waiting      = match_oldest && !bypass;
    assign redirect     = !(hold || hit || bypass || waiting);

    always_comb begin
        state_d   = state_q;
        ibus_req  = 1'b0;
        ibus_addr = stream_addr_q;
        if (redirect) begin
            state_d   = misaligned ? IPF_IDLE : IPF_STREAM;
            ibus_req  = !misaligned;
            ibus_addr = pc_aligned;
        end else if (state_q == IPF_STREAM) begin
            ibus_req = ({1'b0, fifo_count} + {1'b0, live}) < (CNT_W + 1)'(DEPTH);
        end
        if (cpu_rst) begin
            ibus_req  = 1'b0;
            ibus_addr = '0;
        end
    end

    assign xfer        = ibus_req && ibus_gnt;
    assign push        = ibus_rvalid && !redirect && (discard_q == '0) && !bypass;
    assign stream_base = redirect ? pc_aligned : stream_addr_q;

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            state_q       <= IPF_IDLE;
            cur_addr_q    <= '0;
            stream_addr_q <= '0;
            outstanding_q <= '0;
            discard_q     <= '0;
            valid_q       <= 1'b0;
            data_q        <= '0;
        end else begin
            state_q       <= state_d;
            cur_addr_q    <= next_pc;
            stream_addr_q <= xfer ? stream_base + ADDR_WIDTH'(IPF_WORD_BYTES) : stream_base;
            outstanding_q <= outstanding_q + CNT_W'(xfer) - CNT_W'(ibus_rvalid);
            // A response landing on the redirect cycle is consumed now, so it leaves the discard set.
            if (redirect) begin
                discard_q <= outstanding_q - CNT_W'(ibus_rvalid);
            end else if (ibus_rvalid && (discard_q != '0)) begin
                discard_q <= discard_q - CNT_W'(1);
            end
            if (hit) begin
                valid_q <= 1'b1;
                data_q  <= head.instr;
            end else if (bypass) begin
                valid_q <= 1'b1;
                data_q  <= ibus_rdata;
            end else if (!hold) begin
                valid_q <= 1'b0;
            end
        end
    end

    ipf_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_fifo (
        .cpu_clk  (cpu_clk),
        .cpu_rst  (cpu_rst),
        .push     (push),
        .push_dat (push_entry),
        .pop      (hit),
        .clear    (redirect),
        .head_dat (head_dat),
        .count    (fifo_count),
        .empty    (fifo_empty)
    );

    assign instr_read_data_valid = valid_q;
    assign instr_read_data       = data_q;

`ifdef KRV_IPF_PERF_CNT_EN
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            ipf_hit_cnt      <= '0;
            ipf_redirect_cnt <= '0;
        end else begin
            if ((hit || bypass) && (ipf_hit_cnt != '1)) ipf_hit_cnt <= ipf_hit_cnt + 32'd1;
            if (redirect && (ipf_redirect_cnt != '1))   ipf_redirect_cnt <= ipf_redirect_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_prefetch_buf.sv
// Bench for instr_prefetch_buf: queue-based reference model, in-order bus model with random latency, IF-stage stimulus.
module tb_instr_prefetch_buf;
    localparam int DEPTH = 4;

    logic        cpu_clk = 1'b0;
    logic        cpu_rst = 1'b1;
    logic [31:0] next_pc = '0;
    logic        instr_read_data_valid;
    logic [31:0] instr_read_data;
    logic        ibus_req;
    logic [31:0] ibus_addr;
    logic        ibus_gnt = 1'b0;
    logic        ibus_rvalid = 1'b0;
    logic [31:0] ibus_rdata = '0;
`ifdef KRV_IPF_PERF_CNT_EN
    logic [31:0] ipf_hit_cnt;
    logic [31:0] ipf_redirect_cnt;
`endif

    always #5 cpu_clk = ~cpu_clk;

    instr_prefetch_buf #(.DEPTH(DEPTH), .ADDR_WIDTH(32), .INSTR_WIDTH(32)) dut (
        .cpu_clk               (cpu_clk),
        .cpu_rst               (cpu_rst),
        .next_pc               (next_pc),
        .instr_read_data_valid (instr_read_data_valid),
        .instr_read_data       (instr_read_data),
        .ibus_req              (ibus_req),
        .ibus_addr             (ibus_addr),
        .ibus_gnt              (ibus_gnt),
        .ibus_rvalid           (ibus_rvalid),
        .ibus_rdata            (ibus_rdata)
`ifdef KRV_IPF_PERF_CNT_EN
        ,
        .ipf_hit_cnt           (ipf_hit_cnt),
        .ipf_redirect_cnt      (ipf_redirect_cnt)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge cpu_clk) cyc <= cyc + 1;

    // Reference state: buffered word addresses, in-flight requests, stream pointer, IF-visible outputs.
    typedef struct {logic [31:0] addr; bit drop;} inflight_t;
    typedef struct {logic [31:0] addr; int ready;} bus_t;
    logic [31:0] m_fifo[$];
    inflight_t   m_infl[$];
    bus_t        bus_q[$];
    logic [31:0] m_stream, m_cur, m_data, m_hits, m_redirs;
    bit          m_streaming, m_valid;
    int          bus_lat_max = 1;
    logic        s_req;
    logic [31:0] s_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_fifo.delete(); m_infl.delete(); bus_q.delete();
        m_stream = '0; m_cur = '0; m_data = '0; m_hits = '0; m_redirs = '0;
        m_streaming = 1'b0; m_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge cpu_clk);
        cpu_rst = 1'b1; ibus_gnt = 1'b0; ibus_rvalid = 1'b0;
        @(posedge cpu_clk); #1;
        chk("rst_ibus_req", ibus_req, 32'd0);
        chk("rst_ibus_addr", ibus_addr, 32'd0);
        @(posedge cpu_clk); #1;
        chk("rst_valid", instr_read_data_valid, 32'd0);
        chk("rst_data", instr_read_data, 32'd0);
`ifdef KRV_IPF_PERF_CNT_EN
        chk("rst_hit_cnt", ipf_hit_cnt, 32'd0);
        chk("rst_redirect_cnt", ipf_redirect_cnt, 32'd0);
`endif
        model_reset();
    endtask

    // One IF cycle: drive inputs at negedge, check bus request mid-cycle, advance model, check outputs after posedge.
    task automatic step(input logic [31:0] pc, input bit g, input bit rsp_en);
        bit rv, mis, hold, hit, byp, wt, redir, have_live, exp_req;
        int live;
        logic [31:0] oldest, exp_addr;
        inflight_t h;
        @(negedge cpu_clk);
        cpu_rst = 1'b0; next_pc = pc; ibus_gnt = g;
        rv = rsp_en && (bus_q.size() > 0) && (bus_q[0].ready <= cyc);
        ibus_rvalid = rv;
        ibus_rdata  = rv ? mem_word(bus_q[0].addr) : $urandom;

        mis = (pc[1:0] != 2'b00);
        live = 0; oldest = '0; have_live = 1'b0;
        foreach (m_infl[i]) if (!m_infl[i].drop) begin
            if (!have_live) oldest = m_infl[i].addr;
            have_live = 1'b1; live++;
        end
        hold  = !mis && m_valid && (pc == m_cur);
        hit   = !mis && !hold && (m_fifo.size() > 0) && (m_fifo[0] == pc);
        byp   = !mis && !hold && (m_fifo.size() == 0) && have_live && (oldest == pc) && rv && !m_infl[0].drop;
        wt    = !mis && !hold && (m_fifo.size() == 0) && have_live && (oldest == pc) && !byp;
        redir = !(hold || hit || byp || wt);
        if (redir) begin
            exp_req = !mis; exp_addr = pc;
        end else begin
            exp_req = m_streaming && ((m_fifo.size() + live) < DEPTH); exp_addr = m_stream;
        end

        #1;
        s_req = ibus_req; s_addr = ibus_addr;
        chk("ibus_req", ibus_req, 32'(exp_req));
        if (exp_req) chk("ibus_addr", ibus_addr, exp_addr);
        if (ibus_req && g) bus_q.push_back('{ibus_addr, cyc + int'($urandom_range(bus_lat_max, 1))});
        if (rv) void'(bus_q.pop_front());

        if (rv && (m_infl.size() > 0)) begin
            h = m_infl.pop_front();
            if (!redir && !h.drop && !byp) m_fifo.push_back(h.addr);
        end
        if (hit) void'(m_fifo.pop_front());
        if (redir) begin
            foreach (m_infl[i]) m_infl[i].drop = 1'b1;
            m_fifo.delete();
            m_stream = {pc[31:2], 2'b00};
            m_streaming = !mis;
        end
        if (exp_req && g) begin
            m_infl.push_back('{exp_addr, 1'b0});
            m_stream = exp_addr + 32'd4;
        end
        if (hit || byp) begin
            m_valid = 1'b1; m_data = mem_word(pc);
        end else if (!hold) begin
            m_valid = 1'b0;
        end
        m_cur = pc;
        if ((hit || byp) && (m_hits != 32'hFFFF_FFFF)) m_hits++;
        if (redir && (m_redirs != 32'hFFFF_FFFF)) m_redirs++;

        @(posedge cpu_clk); #1;
        chk("valid", instr_read_data_valid, 32'(m_valid));
        if (m_valid) chk("data", instr_read_data, m_data);
`ifdef KRV_IPF_PERF_CNT_EN
        chk("ipf_hit_cnt", ipf_hit_cnt, m_hits);
        chk("ipf_redirect_cnt", ipf_redirect_cnt, m_redirs);
`endif
    endtask

    task automatic run_until_valid(input string name, input logic [31:0] pc);
        int n = 0;
        do begin
            step(pc, 1'b1, 1'b1);
            n++;
        end while (!instr_read_data_valid && (n < 20));
        chk({name, "_valid"}, instr_read_data_valid, 32'd1);
        chk({name, "_data"}, instr_read_data, mem_word(pc));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] pc;
        int r;
        model_reset();
        do_reset();

        // Stalled bus: exactly DEPTH sequential requests from 0 go out, then the request drops.
        for (int i = 0; i < 5; i++) begin
            step(32'h0, 1'b1, 1'b0);
            if (i < 4) begin
                chk("fill_req", s_req, 32'd1);
                chk("fill_addr", s_addr, 32'(i * 4));
            end else begin
                chk("fill_stop", s_req, 32'd0);
            end
        end

        // One-cycle bus, IF stepping by 4: a word every cycle.
        for (int k = 0; k < 8; k++) begin
            step(32'(k * 4), 1'b1, 1'b1);
            chk("seq_valid", instr_read_data_valid, 32'd1);
            chk("seq_data", instr_read_data, mem_word(32'(k * 4)));
        end

        for (int k = 0; k < 3; k++) begin
            step(32'h1C, 1'b1, 1'b1);
            chk("hold_data", instr_read_data, mem_word(32'h1C));
        end
        for (int k = 8; k < 12; k++) step(32'(k * 4), 1'b1, 1'b1);

        // Redirect with requests in flight; stale responses must never surface.
        for (int k = 0; k < 4; k++) step(32'h2C, 1'b1, 1'b0);
        step(32'h100, 1'b0, 1'b0);
        chk("redir_valid_low", instr_read_data_valid, 32'd0);
        run_until_valid("redir", 32'h100);

        step(32'h102, 1'b1, 1'b1);
        chk("misalign_req", s_req, 32'd0);
        step(32'h102, 1'b1, 1'b1);
        chk("misalign_req2", s_req, 32'd0);
        chk("misalign_valid", instr_read_data_valid, 32'd0);
        run_until_valid("restart", 32'h200);

        // IF stalled with the bus always granting: the buffer fills and the request stops.
        for (int k = 0; k < 10; k++) step(32'h200, 1'b1, 1'b1);
        chk("full_req", s_req, 32'd0);
        step(32'h204, 1'b1, 1'b1);
        step(32'h204, 1'b1, 1'b1);
        chk("resume_req", s_req, 32'd1);

        bus_lat_max = 3;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            r = int'($urandom_range(99, 0));
            if ((m_cur[1:0] != 2'b00) || (!m_valid && (r < 8))) pc = 32'($urandom_range(63, 0)) << 2;
            else if (!m_valid)  pc = m_cur;
            else if (r < 70)    pc = m_cur + 32'd4;
            else if (r < 82)    pc = m_cur;
            else if (r < 94)    pc = 32'($urandom_range(63, 0)) << 2;
            else if (r < 96)    pc = 32'hFFFF_FFF4;
            else                pc = m_cur + 32'd4 + 32'($urandom_range(3, 1));
            step(pc, $urandom_range(3, 0) != 0, $urandom_range(4, 0) != 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
